// File: rtl/hex_display_arbiter_if.sv
// Request/value bus between the hardware display requesters, the CPU PIO and
// the hex display arbiter.
interface hex_display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_value;
  logic [15:0]           cpu_value;
  logic                  cpu_override;
  logic [NUM_REQ-1:0]    grant;
  logic                  cpu_active;
  logic [15:0]           hex_value;

  modport master (
    output req, req_value, cpu_value, cpu_override,
    input  grant, cpu_active, hex_value
  );

  modport slave (
    input  req, req_value, cpu_value, cpu_override,
    output grant, cpu_active, hex_value
  );
endinterface

// File: rtl/hex_display_arbiter.sv
// Shares a four-digit active-low 7-segment display between NUM_REQ hardware
// requesters (round-robin, minimum hold time) and a CPU override source.
module hex_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 5000000,
  parameter int CNT_W       = 23
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hex_display_arbiter_if.slave bus,
  output logic [6:0]           hex0_n,
  output logic [6:0]           hex1_n,
  output logic [6:0]           hex2_n,
  output logic [6:0]           hex3_n
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_CPU} state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [15:0]          hex_value_reg, hex_next;
  logic                 blank_reg, blank_next;
  logic                 cpu_active_reg, cpu_active_next;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [15:0]          win_value;
  logic                 owner_req;
  logic [15:0]          owner_value;

  // rr_ptr doubles as the current owner index while in HOLD. Scanning from
  // rr_ptr+1 with the owner visited last makes "only owner high" a re-grant.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = rr_ptr_reg;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
      if (bus.req[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign win_onehot  = NUM_REQ'(1) << win_idx;
  assign win_value   = bus.req_value[16*win_idx +: 16];
  assign owner_req   = bus.req[rr_ptr_reg];
  assign owner_value = bus.req_value[16*rr_ptr_reg +: 16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= PTR_W'(NUM_REQ - 1);
      cnt_reg        <= '0;
      hex_value_reg  <= '0;
      blank_reg      <= 1'b1;
      cpu_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      rr_ptr_reg     <= rr_ptr_next;
      cnt_reg        <= cnt_next;
      hex_value_reg  <= hex_next;
      blank_reg      <= blank_next;
      cpu_active_reg <= cpu_active_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.cpu_override) begin
      state_next = ST_CPU;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = win_found ? ST_HOLD : ST_IDLE;
        ST_HOLD: if (cnt_reg == '0) state_next = win_found ? ST_HOLD : ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_next      = grant_reg;
    rr_ptr_next     = rr_ptr_reg;
    cnt_next        = cnt_reg;
    hex_next        = hex_value_reg;
    blank_next      = blank_reg;
    cpu_active_next = 1'b0;
    if (bus.cpu_override) begin
      grant_next      = '0;
      cpu_active_next = 1'b1;
      blank_next      = 1'b0;
      hex_next        = bus.cpu_value;
      cnt_next        = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (win_found) begin
            grant_next  = win_onehot;
            rr_ptr_next = win_idx;
            cnt_next    = RELOAD;
            blank_next  = 1'b0;
            hex_next    = win_value;
          end else begin
            grant_next  = '0;
            blank_next  = 1'b1;
          end
        end
        ST_HOLD: begin
          // A dropped owner freezes the display but keeps the grant until expiry.
          if (owner_req) hex_next = owner_value;
          if (cnt_reg == '0) begin
            if (win_found) begin
              grant_next  = win_onehot;
              rr_ptr_next = win_idx;
              cnt_next    = RELOAD;
              hex_next    = win_value;
            end else begin
              grant_next  = '0;
              blank_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          grant_next = '0;
          blank_next = 1'b1;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_reg;
  assign bus.cpu_active = cpu_active_reg;
  assign bus.hex_value  = hex_value_reg;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;  4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;  4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;  4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;  4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;  4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;  4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;  4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;  default: seg_decode = 7'h0E;
    endcase
  endfunction

  logic [6:0] seg [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign seg[gi] = blank_reg ? 7'h7F : seg_decode(hex_value_reg[4*gi +: 4]);
    end
  endgenerate

  assign hex0_n = seg[0];
  assign hex1_n = seg[1];
  assign hex2_n = seg[2];
  assign hex3_n = seg[3];
endmodule
